// File: rtl/convpress_lane_d3_vmode_if.sv
// convpress_lane_d3_vmode_if: beat input and result output handshake bundle for the convpress lane.
interface convpress_lane_d3_vmode_if #(
    parameter int N = 16,
    parameter int Tn = 16,
    parameter int WIN_SZ = 8,
    parameter int OFFSET_SZ = 4
);
    logic                 i_valid;
    logic                 o_up_ready;
    logic [Tn*N-1:0]      i_nbin_data;
    logic [Tn*N-1:0]      i_sb_data;
    logic [1:0]           i_op;
    logic [WIN_SZ-1:0]    i_win_len;
    logic                 i_relu;
    logic                 i_zskip;
    logic                 o_valid;
    logic                 i_dn_ready;
    logic [N-1:0]         o_data;
    logic [OFFSET_SZ-1:0] o_idx;
    modport slave (
        input  i_valid, i_nbin_data, i_sb_data, i_op, i_win_len, i_relu, i_zskip, i_dn_ready,
        output o_up_ready, o_valid, o_data, o_idx
    );
    modport master (
        output i_valid, i_nbin_data, i_sb_data, i_op, i_win_len, i_relu, i_zskip, i_dn_ready,
        input  o_up_ready, o_valid, o_data, o_idx
    );
endinterface

// File: rtl/convpress_lane_d3_vmode.sv
// convpress_lane_d3_vmode: lane-wise multiply, sum/max reduce over a beat window, ReLU and
// zero-skipping indexed output, with a single valid/ready pipeline enable.
module convpress_lane_d3_vmode #(
    parameter int N = 16,
    parameter int Tn = 16,
    parameter int FRAC = 8,
    parameter int ACC_W = 24,
    parameter int WIN_SZ = 8,
    parameter int OFFSET_SZ = 4
) (
    input logic clk,
    input logic rst,
    convpress_lane_d3_vmode_if.slave bus
);
    localparam logic [1:0] OP_MAC = 2'd0;
    localparam logic [1:0] OP_POOL = 2'd2;
    localparam logic signed [2*N-1:0] L_PMAX = (2*N)'(2**(N-1)-1);
    localparam logic signed [2*N-1:0] L_PMIN = ~L_PMAX;
    localparam logic signed [ACC_W-1:0] L_NMAX = ACC_W'(2**(N-1)-1);
    localparam logic signed [ACC_W-1:0] L_NMIN = ~L_NMAX;
    logic w_en, w_acc, w_first, w_last, w_relu, w_zskip, w_load;
    logic [1:0] w_op, r_op_h, r_s1_op;
    logic [WIN_SZ-1:0] w_wl, r_cnt, r_win_h;
    logic r_relu_h, r_zskip_h;
    logic signed [N-1:0] w_p [Tn];
    logic signed [N-1:0] r_p [Tn];
    logic r_s1_v, r_s1_first, r_s1_last, r_s1_relu, r_s1_zskip;
    logic signed [ACC_W-1:0] r_acc, w_tot, w_red, w_new;
    logic signed [ACC_W:0] w_sum;
    logic signed [N-1:0] w_mx, w_sat, w_r, r_data;
    logic [OFFSET_SZ-1:0] r_pos, r_idx;
    logic r_ovalid;
    assign w_en = !r_ovalid | bus.i_dn_ready;
    assign w_acc = bus.i_valid & w_en;
    assign w_first = r_cnt == '0;
    // window controls come live from the inputs on the first beat, then from the held copies
    assign w_op = w_first ? (bus.i_op == 2'd3 ? OP_MAC : bus.i_op) : r_op_h;
    assign w_wl = w_first ? bus.i_win_len : r_win_h;
    assign w_relu = w_first ? bus.i_relu : r_relu_h;
    assign w_zskip = w_first ? bus.i_zskip : r_zskip_h;
    assign w_last = r_cnt == (w_wl == '0 ? '0 : w_wl - WIN_SZ'(1));
    for (genvar k = 0; k < Tn; k++) begin : g_lane
        logic signed [2*N-1:0] w_a, w_b, w_s;
        assign w_a = {{N{bus.i_nbin_data[k*N+N-1]}}, bus.i_nbin_data[k*N +: N]};
        assign w_b = {{N{bus.i_sb_data[k*N+N-1]}}, bus.i_sb_data[k*N +: N]};
        assign w_s = (w_a * w_b) >>> FRAC;
        assign w_p[k] = w_op == OP_POOL ? w_a[N-1:0] : w_s > L_PMAX ? L_PMAX[N-1:0] :
                        w_s < L_PMIN ? L_PMIN[N-1:0] : w_s[N-1:0];
    end
    always_comb begin
        w_tot = '0;
        w_mx = r_p[0];
        for (int k = 0; k < Tn; k++) begin
            w_tot = w_tot + ACC_W'(r_p[k]);
            w_mx = r_p[k] > w_mx ? r_p[k] : w_mx;
        end
        w_red = r_s1_op == OP_MAC ? w_tot : ACC_W'(w_mx);
        w_sum = {r_acc[ACC_W-1], r_acc} + {w_red[ACC_W-1], w_red};
        w_new = r_s1_first ? w_red : r_s1_op != OP_MAC ? (w_red > r_acc ? w_red : r_acc) :
                w_sum[ACC_W] != w_sum[ACC_W-1] ? {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}} :
                w_sum[ACC_W-1:0];
        w_sat = w_new > L_NMAX ? L_NMAX[N-1:0] : w_new < L_NMIN ? L_NMIN[N-1:0] : w_new[N-1:0];
        w_r = (r_s1_relu && w_sat[N-1]) ? '0 : w_sat;
        w_load = w_en & r_s1_v & r_s1_last & !(r_s1_zskip & (w_r == '0));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_op_h <= '0;
            r_win_h <= '0;
            r_relu_h <= 1'b0;
            r_zskip_h <= 1'b0;
            r_s1_v <= 1'b0;
            r_s1_op <= '0;
            r_s1_first <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_relu <= 1'b0;
            r_s1_zskip <= 1'b0;
            r_acc <= '0;
            r_pos <= '0;
            r_idx <= '0;
            r_data <= '0;
            r_ovalid <= 1'b0;
        end else if (w_en) begin
            if (w_acc) begin
                r_cnt <= w_last ? '0 : r_cnt + WIN_SZ'(1);
                if (w_first) begin
                    r_op_h <= w_op;
                    r_win_h <= w_wl;
                    r_relu_h <= w_relu;
                    r_zskip_h <= w_zskip;
                end
                r_p <= w_p;
                r_s1_op <= w_op;
                r_s1_first <= w_first;
                r_s1_last <= w_last;
                r_s1_relu <= w_relu;
                r_s1_zskip <= w_zskip;
            end
            r_s1_v <= w_acc;
            if (r_s1_v && !r_s1_last) r_acc <= w_new;
            // every window result takes a position, even when it is skipped as zero
            if (r_s1_v && r_s1_last) r_pos <= r_pos + OFFSET_SZ'(1);
            if (w_load) begin
                r_data <= w_r;
                r_idx <= r_pos;
            end
            r_ovalid <= w_load;
        end
    end
    assign bus.o_up_ready = w_en;
    assign bus.o_valid = r_ovalid;
    assign bus.o_data = r_data;
    assign bus.o_idx = r_idx;
endmodule

// File: tb/tb_convpress_lane_d3_vmode.sv
// tb_convpress_lane_d3_vmode: directed cases plus randomized windows under backpressure,
// checked against an arithmetic reference model of the window results.
module tb_convpress_lane_d3_vmode;
    localparam int N = 16, Tn = 16, FRAC = 8, ACC_W = 24, WIN_SZ = 8, OFFSET_SZ = 4;
    localparam int W = Tn * N;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_assert = 0, n_fail = 0, pos = 0;
    bit gaps = 1'b0, rnd_dn = 1'b0;
    logic [N+OFFSET_SZ-1:0] exp_q[$], got_q[$];
    logic [W-1:0] nb, sb;

    convpress_lane_d3_vmode_if #(.N(N), .Tn(Tn), .WIN_SZ(WIN_SZ), .OFFSET_SZ(OFFSET_SZ)) bus ();
    convpress_lane_d3_vmode #(.N(N), .Tn(Tn), .FRAC(FRAC), .ACC_W(ACC_W), .WIN_SZ(WIN_SZ),
        .OFFSET_SZ(OFFSET_SZ)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clamp(input longint x, input int bits);
        longint lo = -(longint'(1) << (bits - 1));
        longint hi = -lo - 1;
        return x > hi ? hi : x < lo ? lo : x;
    endfunction

    function automatic logic [W-1:0] rnd_vec(input int mode);
        logic [W-1:0] v = '0;
        for (int k = 0; k < Tn; k++)
            v[k*N +: N] = mode == 0 ? N'($urandom) : mode == 1 ? N'($urandom_range(0, 2047) - 1024) :
                          (mode == 2 && $urandom_range(0, 3) == 0) ? N'($urandom_range(0, 511) - 256) : '0;
        return v;
    endfunction

    function automatic longint lane_red(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input int op);
        longint s = 0, m = 0, p;
        logic signed [N-1:0] a, b;
        for (int k = 0; k < Tn; k++) begin
            a = a_v[k*N +: N];
            b = b_v[k*N +: N];
            p = (op == 2) ? longint'(a) : clamp((longint'(a) * longint'(b)) >>> FRAC, N);
            s += p;
            if (k == 0 || p > m) m = p;
        end
        return (op == 0) ? s : m;
    endfunction

    // returns just after the clock edge on which the beat was accepted
    task automatic beat(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic [1:0] op,
                        input logic [WIN_SZ-1:0] wl, input logic relu, input logic zs);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            bus.i_valid = 1'b0;
            tick();
        end
        bus.i_valid = 1'b1;
        bus.i_nbin_data = a_v;
        bus.i_sb_data = b_v;
        bus.i_op = op;
        bus.i_win_len = wl;
        bus.i_relu = relu;
        bus.i_zskip = zs;
        @(negedge clk);
        while (!bus.o_up_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("beat_accept", bus.o_up_ready, 1);
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic window(input int op, input int wl, input bit relu, input bit zs);
        int ew = (wl == 0) ? 1 : wl;
        int mode = $urandom_range(0, 3);
        int opm = (op == 3) ? 0 : op;
        longint acc = 0, red, r;
        logic [W-1:0] a_v, b_v;
        for (int b = 0; b < ew; b++) begin
            a_v = rnd_vec(mode);
            b_v = rnd_vec(mode);
            red = lane_red(a_v, b_v, opm);
            acc = (b == 0) ? red : (opm == 0) ? clamp(acc + red, ACC_W) : (red > acc ? red : acc);
            if (b == 0) beat(a_v, b_v, 2'(op), WIN_SZ'(wl), relu, zs);
            else beat(a_v, b_v, 2'($urandom), WIN_SZ'($urandom), 1'($urandom), 1'($urandom));
        end
        r = clamp(acc, N);
        if (relu && r < 0) r = 0;
        if (!(zs && r == 0)) exp_q.push_back({N'(r), OFFSET_SZ'(pos)});
        pos = (pos + 1) % (1 << OFFSET_SZ);
    endtask

    task automatic expect_res(input logic [N-1:0] d, input logic [OFFSET_SZ-1:0] idx);
        exp_q.push_back({d, idx});
    endtask

    task automatic drain();
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 4000) begin
            @(posedge clk);
            t++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("result_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("result_%0d", i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic reset_dut();
        bus.i_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pos = 0;
    endtask

    always @(negedge clk) if (!rst) begin
        if (bus.o_valid && bus.i_dn_ready) got_q.push_back({bus.o_data, bus.o_idx});
        if (bus.o_valid && !bus.i_dn_ready) chk("backpressure_up_ready", bus.o_up_ready, 0);
    end

    initial begin
        bus.i_dn_ready = 1'b1;
        forever begin
            tick();
            bus.i_dn_ready = rnd_dn ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_nbin_data = '0;
        bus.i_sb_data = '0;
        bus.i_op = '0;
        bus.i_win_len = '0;
        bus.i_relu = 1'b0;
        bus.i_zskip = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_data", bus.o_data, 0);
        chk("rst_o_idx", bus.o_idx, 0);
        chk("rst_up_ready", bus.o_up_ready, 1);
        tick();
        nb = {Tn{16'h0100}};
        sb = {Tn{16'h0200}};
        beat(nb, sb, 2'd0, 8'd2, 1'b0, 1'b0);
        beat(nb, sb, 2'd0, 8'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("mac_latency_c1", bus.o_valid, 0);
        @(negedge clk);
        chk("mac_latency_c2", bus.o_valid, 1);
        chk("mac_data", bus.o_data, 16'h4000);
        tick();
        expect_res(16'h4000, 4'd0);
        drain();
        beat({Tn{16'h7FFF}}, {Tn{16'h7FFF}}, 2'd0, 8'd1, 1'b0, 1'b0);
        beat({Tn{16'h8000}}, {Tn{16'h7FFF}}, 2'd0, 8'd1, 1'b0, 1'b0);
        expect_res(16'h7FFF, 4'd1);
        expect_res(16'h8000, 4'd2);
        nb = {Tn{16'h0100}};
        nb[5*N +: N] = 16'h0300;
        sb = {Tn{16'h0100}};
        beat(nb, sb, 2'd1, 8'd2, 1'b0, 1'b0);
        nb = {Tn{16'h0100}};
        nb[0 +: N] = 16'h0400;
        beat(nb, sb, 2'd1, 8'd2, 1'b0, 1'b0);
        expect_res(16'h0400, 4'd3);
        nb = {Tn{16'h8000}};
        nb[9*N +: N] = 16'h0A00;
        beat(nb, rnd_vec(0), 2'd2, 8'd1, 1'b0, 1'b0);
        expect_res(16'h0A00, 4'd4);
        drain();
        reset_dut();
        sb = {Tn{16'h0100}};
        nb = '0;
        nb[0 +: N] = 16'h0100;
        beat(nb, sb, 2'd0, 8'd1, 1'b1, 1'b1);
        nb[0 +: N] = 16'hFF00;
        beat(nb, sb, 2'd0, 8'd1, 1'b1, 1'b1);
        nb = '0;
        beat(nb, sb, 2'd0, 8'd1, 1'b1, 1'b1);
        nb[0 +: N] = 16'h0200;
        beat(nb, sb, 2'd0, 8'd1, 1'b1, 1'b1);
        expect_res(16'h0100, 4'd0);
        expect_res(16'h0200, 4'd3);
        drain();
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            nb = '0;
            nb[0 +: N] = 16'((i + 1) << 8);
            beat(nb, sb, 2'd0, 8'd1, 1'b0, 1'b0);
            expect_res(16'((i + 1) << 8), 4'(i % 16));
        end
        drain();
        reset_dut();
        gaps = 1'b1;
        rnd_dn = 1'b1;
        repeat (200) window($urandom_range(0, 3),
                           $urandom_range(0, 99) < 85 ? $urandom_range(0, 5) : $urandom_range(6, 20),
                           1'($urandom), 1'($urandom));
        drain();
        gaps = 1'b0;
        rnd_dn = 1'b0;
        tick();
        nb = '0;
        nb[0 +: N] = 16'h0100;
        sb = {Tn{16'h0100}};
        repeat (3) beat(nb, sb, 2'd0, 8'd5, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pos = 0;
        @(negedge clk);
        chk("midrst_o_valid", bus.o_valid, 0);
        chk("midrst_o_data", bus.o_data, 0);
        chk("midrst_o_idx", bus.o_idx, 0);
        tick();
        sb = {Tn{16'h0300}};
        beat(nb, sb, 2'd0, 8'd1, 1'b0, 1'b0);
        expect_res(16'h0300, 4'd0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/convpress_lane_d3_vmode.md
# convpress_lane_d3_vmode

Parametrised single-output-lane datapath for the next-generation convpress node. Each accepted beat carries Tn neuron inputs and Tn synapses. The block multiplies them lane-wise and reduces them by sum or max. It accumulates over a programmable window of beats, applies optional ReLU, and emits results through a zero-skipping compressor with position indices. It extends the fixed adder-tree/max N1 stage with run-time op select, window counting, valid/ready flow control, and built-in sparsity output, and sits between the NBin/SB readout and the NBout/eDRAM writeback.

## Interface
- N, 16, data width (signed fixed point)
- Tn, 16, lanes per beat (power of 2, ≥2)
- FRAC, 8, fractional bits of the data format
- ACC_W, 24, accumulator width (≥ N+log2(Tn))
- WIN_SZ, 8, window-length counter width
- OFFSET_SZ, 4, output index width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  beat valid
- o_up_ready  out  1  beat accepted when i_valid & o_up_ready
- i_nbin_data  in  Tn*N  neuron inputs, lane k = bits [k*N +: N]
- i_sb_data  in  Tn*N  synapses, same packing
- i_op  in  2  0 MAC, 1 MAX-of-products, 2 POOL (max of raw nbin), 3 treated as 0
- i_win_len  in  WIN_SZ  beats per window; 0 treated as 1
- i_relu  in  1  clamp negative results to 0
- i_zskip  in  1  suppress zero results
- o_valid  out  1  result valid
- i_dn_ready  in  1  result consumed when o_valid & i_dn_ready
- o_data  out  N  result
- o_idx  out  OFFSET_SZ  result position within the output stream (wraps mod 2^OFFSET_SZ)

## Operation
- Pipeline enable: en = !o_valid | i_dn_ready. o_up_ready = en. All stage registers hold when en=0.
- S1 (on accepted beat): register Tn products p_k = sat_N((nbin_k * sb_k) >>> FRAC). Use a signed 2N-bit product and an arithmetic shift. Saturate to [-2^(N-1), 2^(N-1)-1]. For POOL, register the raw nbin_k instead. Also register op, first-of-window flag, last-of-window flag, relu, and zskip.
- Window counter (WIN_SZ bits): 0 at reset. On each accepted beat, first = (cnt==0). op, win_len, relu, and zskip are sampled on the first beat and held for the window. last = (cnt == max(win_len,1)-1). The counter wraps to 0 after last, else increments. Mid-window changes to these inputs are ignored.
- S2 reduce (when s1 is valid and en=1):
  - MAC: red = sign-extended sum of the Tn products at ACC_W. new = first ? red : sat_ACC(acc + red).
  - MAX and POOL: red = signed max over lanes. new = first ? red : max(acc, red).
  - If not last: acc <= new.
  - If last: r = sat_N(new) (a no-op for max modes). If relu and r<0, r = 0.
- Compressor: on every last beat, form the result r.
  - If zskip and r==0, drop it: the output register is not loaded.
  - Otherwise o_data <= r, o_idx <= pos, o_valid <= 1.
  - pos increments on every result, dropped or emitted.
- o_valid clears on consume unless a new result loads in the same cycle. Load-plus-consume in one cycle is legal and back-to-back.

## Timing
- Reset: o_valid=0, o_data=0, o_idx=0, pos=0, window cnt=0, s1 valid=0, acc=0. o_up_ready=1 in the first cycle after reset.
- Latency: the last beat handshakes in cycle c; o_valid=1 in cycle c+2 with no stall. Throughput is 1 beat/cycle.
- Backpressure: with o_valid=1 and i_dn_ready=0, o_up_ready=0 in the same cycle (combinational). The pipeline freezes without loss or duplication.
- Reset mid-window or with o_valid high discards all in-flight data. The next beat is the first of a new window with pos=0.
- win_len=1: every beat is both first and last.

## Test plan
- MAC, Tn=16, FRAC=8, win_len=2, all nbin=0x0100, sb=0x0200 for 2 beats -> one result o_data=0x4000, o_idx=0, o_valid exactly 2 cycles after the 2nd beat.
- Saturation: win_len=1, all nbin=sb=0x7FFF -> o_data=0x7FFF. All nbin=0x8000, sb=0x7FFF -> o_data=0x8000.
- MAX, win_len=2: beat1 products 1.0 except lane5 = 3.0 (0x0300); beat2 lane0 = 4.0 -> o_data=0x0400. POOL win_len=1: nbin lane9=0x0A00, others 0x8000, sb arbitrary -> 0x0A00.
- relu=1, zskip=1, win_len=1 MAC results 1.0, -1.0, 0, 2.0 -> emits 0x0100 idx0 then 0x0200 idx3; only 2 o_valid pulses. 17 results with zskip=0 -> o_idx wraps 15 -> 0.
- Backpressure: random i_valid and i_dn_ready, 200 windows of mixed ops -> output stream matches the reference model exactly. o_up_ready=0 whenever o_valid & !i_dn_ready.
- Assert rst mid-window (cnt=3 of 5) -> outputs are 0 the next cycle. A following win_len=1 MAC beat yields idx0 with no leftover accumulation.
